// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
// Shares the register-file write port between the WriteBack stage (highest
// priority), a multiply/divide unit and the IO load path. The two secondary
// requesters use valid/ready handshakes and are served round-robin whenever
// the pipeline leaves a bubble. The Rf* outputs are registered, so a grant in
// cycle N is written in cycle N+1.
//
// Build option: define WB_STARVE_GUARD_EN to enable the starvation guard.
// When a secondary has waited STARVE_MAX cycles, the guard forces a one-cycle
// STEAL slot that stalls the pipeline. Without the macro, secondaries are only
// served in bubbles and PipeStall is tied low.

module wb_write_arbiter #(
  parameter int AW           = 4,
  parameter int DW           = 32,
  parameter int STARVE_MAX   = 8,
  parameter int ZERO_DISCARD = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          PipeWe,
  input  logic [AW-1:0] PipeRd,
  input  logic [DW-1:0] PipeData,
  input  logic          MdValid,
  input  logic [AW-1:0] MdRd,
  input  logic [DW-1:0] MdData,
  output logic          MdReady,
  input  logic          IoValid,
  input  logic [AW-1:0] IoRd,
  input  logic [DW-1:0] IoData,
  output logic          IoReady,
  output logic          RfWe,
  output logic [AW-1:0] RfAddr,
  output logic [DW-1:0] RfData,
  output logic [1:0]    RfSrc,
  output logic          PipeStall
);

  typedef enum logic [1:0] {
    SRC_PIPE = 2'b00,
    SRC_MD   = 2'b01,
    SRC_IO   = 2'b10,
    SRC_NONE = 2'b11
  } src_e;

  // Reject an out-of-range starvation limit at elaboration time.
  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("wb_write_arbiter: STARVE_MAX must be in 1..255");
  end

  logic steal;      // this cycle is a forced steal slot
  logic rr_io;      // round-robin pointer: 0 = MD wins a tie, 1 = IO wins
  logic pipe_go;
  logic md_go;
  logic io_go;

  logic          wr_go;
  logic          wr_keep;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  src_e          wr_src;

`ifdef WB_STARVE_GUARD_EN
  typedef enum logic {
    NORMAL = 1'b0,
    STEAL  = 1'b1
  } state_e;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_e     state;
  logic [7:0] wait_cnt;
  logic       waiting;

  assign steal   = (state == STEAL);
  assign waiting = (MdValid | IoValid) & ~md_go & ~io_go;

  // Starvation guard: count consecutive cycles in which a secondary waits
  // unserved; the cycle that brings the count to STARVE_MAX also arms STEAL,
  // so the steal slot follows exactly STARVE_MAX waiting cycles.
  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      case (state)
        NORMAL: begin
          if (!waiting) begin
            wait_cnt <= '0;
          end else if (wait_cnt >= STARVE_LIM - 8'd1) begin
            wait_cnt <= STARVE_LIM;
            state    <= STEAL;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        STEAL: begin
          wait_cnt <= '0;
          state    <= NORMAL;
        end
        default: begin
          wait_cnt <= '0;
          state    <= NORMAL;
        end
      endcase
    end
  end
`else
  assign steal = 1'b0;
`endif

  // Grant selection: the pipe wins unless this is a steal slot; otherwise the
  // valid secondary wins, with the round-robin pointer breaking ties.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the branches leaves a signal unassigned and infers a latch.
  always_comb begin
    pipe_go = 1'b0;
    md_go   = 1'b0;
    io_go   = 1'b0;
    if (!steal && PipeWe) begin
      pipe_go = 1'b1;
    end else if (MdValid && IoValid) begin
      if (rr_io) io_go = 1'b1;
      else       md_go = 1'b1;
    end else if (MdValid) begin
      md_go = 1'b1;
    end else if (IoValid) begin
      io_go = 1'b1;
    end
  end

  // Ready is gated by rst_n so a grant vanishes the instant reset asserts.
  assign MdReady   = rst_n & md_go;
  assign IoReady   = rst_n & io_go;
  assign PipeStall = steal;

  // Write-port mux for the winning source.
  always_comb begin
    wr_go   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_src  = SRC_NONE;
    if (pipe_go) begin
      wr_go   = 1'b1;
      wr_addr = PipeRd;
      wr_data = PipeData;
      wr_src  = SRC_PIPE;
    end else if (md_go) begin
      wr_go   = 1'b1;
      wr_addr = MdRd;
      wr_data = MdData;
      wr_src  = SRC_MD;
    end else if (io_go) begin
      wr_go   = 1'b1;
      wr_addr = IoRd;
      wr_data = IoData;
      wr_src  = SRC_IO;
    end
  end

  // A handshake to r0 still completes, but the write itself is dropped.
  assign wr_keep = wr_go && !((ZERO_DISCARD != 0) && (wr_addr == '0));

  // Round-robin pointer: after a secondary grant, the other requester wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_io <= 1'b0;
    end else if (md_go) begin
      rr_io <= 1'b1;
    end else if (io_go) begin
      rr_io <= 1'b0;
    end
  end

  // Registered register-file port; address/data hold when nothing is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RfWe   <= 1'b0;
      RfAddr <= '0;
      RfData <= '0;
      RfSrc  <= SRC_NONE;
    end else begin
      RfWe  <= wr_keep;
      RfSrc <= wr_keep ? wr_src : SRC_NONE;
      if (wr_keep) begin
        RfAddr <= wr_addr;
        RfData <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Testbench for wb_write_arbiter (ZERO_DISCARD=1, STARVE_MAX=8). Expected
// register-file writes are queued with the cycle in which they must appear; a
// monitor on the falling edge pops and compares them. Handshake outputs are
// checked directly by the stimulus one time unit after the inputs change.

module tb_wb_write_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          PipeWe = 1'b0;
  logic [AW-1:0] PipeRd = '0;
  logic [DW-1:0] PipeData = '0;
  logic          MdValid = 1'b0;
  logic [AW-1:0] MdRd = '0;
  logic [DW-1:0] MdData = '0;
  logic          MdReady;
  logic          IoValid = 1'b0;
  logic [AW-1:0] IoRd = '0;
  logic [DW-1:0] IoData = '0;
  logic          IoReady;
  logic          RfWe;
  logic [AW-1:0] RfAddr;
  logic [DW-1:0] RfData;
  logic [1:0]    RfSrc;
  logic          PipeStall;

  always #5 clk = ~clk;

  wb_write_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(8), .ZERO_DISCARD(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .PipeWe(PipeWe), .PipeRd(PipeRd), .PipeData(PipeData),
    .MdValid(MdValid), .MdRd(MdRd), .MdData(MdData), .MdReady(MdReady),
    .IoValid(IoValid), .IoRd(IoRd), .IoData(IoData), .IoReady(IoReady),
    .RfWe(RfWe), .RfAddr(RfAddr), .RfData(RfData), .RfSrc(RfSrc),
    .PipeStall(PipeStall)
  );

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    src;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare the registered write port against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        check("rf_missing_cycle", 64'(mon_e.cyc), 64'(cyc));
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_e = exp_q.pop_front();
        if (mon_e.we)
          check("rf_write", {RfWe, RfSrc, RfAddr, RfData}, {1'b1, mon_e.src, mon_e.addr, mon_e.data});
        else
          check("rf_discard", {RfWe, RfSrc}, {1'b0, 2'b11});
      end else if (RfWe || RfSrc != 2'b11) begin
        check("rf_unexpected", {RfWe, RfSrc}, {1'b0, 2'b11});
      end
    end
  end

  task automatic set_in(input logic pw, input logic [AW-1:0] prd, input logic [DW-1:0] pd,
                        input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                        input logic iv, input logic [AW-1:0] ird, input logic [DW-1:0] id);
    PipeWe = pw;  PipeRd = prd; PipeData = pd;
    MdValid = mv; MdRd = mrd;   MdData = md;
    IoValid = iv; IoRd = ird;   IoData = id;
  endtask

  task automatic idle();
    set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Check the combinational handshake outputs shortly after inputs settle.
  task automatic hs(input string tag, input logic e_md, input logic e_io, input logic e_stall);
    #1;
    check({tag, "_md_ready"}, 64'(MdReady), 64'(e_md));
    check({tag, "_io_ready"}, 64'(IoReady), 64'(e_io));
    check({tag, "_stall"}, 64'(PipeStall), 64'(e_stall));
  endtask

  // Expect a write (or a discarded grant when we=0) in the next cycle.
  task automatic push_wr(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [1:0] src);
    exp_t e;
    e.cyc = cyc + 1; e.we = we; e.addr = addr; e.data = data; e.src = src;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset held while inputs toggle: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(i[0], 4'd3, 32'h1111_0000 + i, 1'b1, 4'd5, 32'h22, 1'b1, 4'd6, 32'h33);
      hs("reset", 1'b0, 1'b0, 1'b0);
      check("reset_rf_we", 64'(RfWe), 64'd0);
      check("reset_rf_src", 64'(RfSrc), 64'd3);
    end
    @(negedge clk);
    idle();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // First pipe write.
    @(negedge clk);
    set_in(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, '0, '0);
    hs("pipe_first", 1'b0, 1'b0, 1'b0);
    push_wr(1'b1, 4'd3, 32'hDEAD_BEEF, 2'b00);

    // Bubble grants: MD alone, then IO alone (pointer ends on MD).
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b1, 4'd5, 32'h12, 1'b0, '0, '0);
    hs("bubble_md", 1'b1, 1'b0, 1'b0);
    push_wr(1'b1, 4'd5, 32'h12, 2'b01);
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd9, 32'h99);
    hs("bubble_io", 1'b0, 1'b1, 1'b0);
    push_wr(1'b1, 4'd9, 32'h99, 2'b10);
    @(negedge clk);
    idle();
    hs("idle_a", 1'b0, 1'b0, 1'b0);

    // Round-robin with both requesters held valid: MD, IO, MD, IO.
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hB1);
    hs("rr0_md", 1'b1, 1'b0, 1'b0);
    push_wr(1'b1, 4'd1, 32'hA1, 2'b01);
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b1, 4'd4, 32'hA2, 1'b1, 4'd2, 32'hB1);
    hs("rr1_io", 1'b0, 1'b1, 1'b0);
    push_wr(1'b1, 4'd2, 32'hB1, 2'b10);
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b1, 4'd4, 32'hA2, 1'b1, 4'd6, 32'hB2);
    hs("rr2_md", 1'b1, 1'b0, 1'b0);
    push_wr(1'b1, 4'd4, 32'hA2, 2'b01);
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b1, 4'd8, 32'hA3, 1'b1, 4'd6, 32'hB2);
    hs("rr3_io", 1'b0, 1'b1, 1'b0);
    push_wr(1'b1, 4'd6, 32'hB2, 2'b10);

    // Pipe priority over a waiting MD request, then MD in the bubble.
    @(negedge clk);
    set_in(1'b1, 4'd11, 32'hBBBB, 1'b1, 4'd12, 32'hCC, 1'b0, '0, '0);
    hs("prio_pipe", 1'b0, 1'b0, 1'b0);
    push_wr(1'b1, 4'd11, 32'hBBBB, 2'b00);
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b1, 4'd12, 32'hCC, 1'b0, '0, '0);
    hs("prio_md", 1'b1, 1'b0, 1'b0);
    push_wr(1'b1, 4'd12, 32'hCC, 2'b01);

    // Zero discard: MD grant to r0 completes, nothing written; pipe to r0 too.
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b1, 4'd0, 32'h5A5A, 1'b0, '0, '0);
    hs("zero_md", 1'b1, 1'b0, 1'b0);
    push_wr(1'b0, '0, '0, 2'b11);
    @(negedge clk);
    set_in(1'b1, 4'd0, 32'h7777, 1'b0, '0, '0, 1'b0, '0, '0);
    hs("zero_pipe", 1'b0, 1'b0, 1'b0);
    push_wr(1'b0, '0, '0, 2'b11);
    @(negedge clk);
    idle();
    hs("idle_b", 1'b0, 1'b0, 1'b0);

`ifdef WB_STARVE_GUARD_EN
    // Starvation: 8 waiting cycles, then one steal slot serving IO.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      set_in(1'b1, 4'(k + 1), 32'h100 + k, 1'b0, '0, '0, 1'b1, 4'd7, 32'h77);
      hs("starve_wait", 1'b0, 1'b0, 1'b0);
      push_wr(1'b1, 4'(k + 1), 32'h100 + k, 2'b00);
    end
    @(negedge clk);
    set_in(1'b1, 4'd14, 32'hE0E0, 1'b0, '0, '0, 1'b1, 4'd7, 32'h77);
    hs("steal", 1'b0, 1'b1, 1'b1);
    push_wr(1'b1, 4'd7, 32'h77, 2'b10);
    @(negedge clk);
    set_in(1'b1, 4'd14, 32'hE0E0, 1'b0, '0, '0, 1'b0, '0, '0);
    hs("after_steal", 1'b0, 1'b0, 1'b0);
    push_wr(1'b1, 4'd14, 32'hE0E0, 2'b00);
    @(negedge clk);
    idle();

    // Async reset in the middle of a steal slot.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      set_in(1'b1, 4'd13, 32'h200 + k, 1'b1, 4'd10, 32'hAA, 1'b0, '0, '0);
      hs("starve2_wait", 1'b0, 1'b0, 1'b0);
      push_wr(1'b1, 4'd13, 32'h200 + k, 2'b00);
    end
    @(negedge clk);
    set_in(1'b1, 4'd13, 32'h208, 1'b1, 4'd10, 32'hAA, 1'b0, '0, '0);
    hs("steal2", 1'b1, 1'b0, 1'b1);
`else
    // No guard: IO starves while the pipe keeps writing.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      set_in(1'b1, 4'(k + 1), 32'h100 + k, 1'b0, '0, '0, 1'b1, 4'd7, 32'h77);
      hs("starve_wait", 1'b0, 1'b0, 1'b0);
      push_wr(1'b1, 4'(k + 1), 32'h100 + k, 2'b00);
    end
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd7, 32'h77);
    hs("starve_bubble", 1'b0, 1'b1, 1'b0);
    push_wr(1'b1, 4'd7, 32'h77, 2'b10);
    @(negedge clk);
    idle();

    // Async reset while an MD grant is live.
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b1, 4'd10, 32'hAA, 1'b0, '0, '0);
    hs("grant_live", 1'b1, 1'b0, 1'b0);
`endif
    #2;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    check("async_rst_stall", 64'(PipeStall), 64'd0);
    check("async_rst_md_ready", 64'(MdReady), 64'd0);
    check("async_rst_io_ready", 64'(IoReady), 64'd0);
    check("async_rst_rf_we", 64'(RfWe), 64'd0);
    @(negedge clk);
    idle();
    check("rst_hold_rf_we", 64'(RfWe), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("post_rst_rf_we", 64'(RfWe), 64'd0);
      check("post_rst_stall", 64'(PipeStall), 64'd0);
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, reached time %0t", $time);
    $fatal(1, "watchdog timeout");
  end

endmodule
